// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the convolution control FSM: state
// encoding, default frame/kernel geometry and a counter-width helper.
package cnn_ctrl_pkg;

  localparam int DEF_IMG_W   = 32;
  localparam int DEF_IMG_H   = 32;
  localparam int DEF_KERNEL  = 5;
  localparam int DEF_NUM_CH  = 6;
  localparam int DEF_POOL_EN = 1;

  // One-hot encoding keeps each Moore output a single-bit decode.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LOAD = 5'b00010,
    S_FILL = 5'b00100,
    S_CONV = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm_conv_ctrl_if.sv
// Bundle of the control handshake between the pixel source / conv engine
// (master side drives the strobes) and fsm_conv_ctrl (slave side).
interface fsm_conv_ctrl_if
  import cnn_ctrl_pkg::*;
#(
  parameter int CH_W = cnt_w(DEF_NUM_CH)
) ();

  logic            sof_i;
  logic            data_valid_i;
  logic            sram_cnt_done_i;
  logic            conv_compute_out_valid_i;
  logic            load_counters_ctrl_o;
  logic            load_sram_reg_en_ctrl_o;
  logic            lb_pxl_cnt_en_ctrl_o;
  logic            lb_pool_cnt_en_ctrl_o;
  logic            win_valid_o;
  logic [CH_W-1:0] ch_idx_o;
  logic            frame_done_o;
  logic            sof_err_o;

  modport master (
    output sof_i, data_valid_i, sram_cnt_done_i, conv_compute_out_valid_i,
    input  load_counters_ctrl_o, load_sram_reg_en_ctrl_o, lb_pxl_cnt_en_ctrl_o,
           lb_pool_cnt_en_ctrl_o, win_valid_o, ch_idx_o, frame_done_o, sof_err_o
  );

  modport slave (
    input  sof_i, data_valid_i, sram_cnt_done_i, conv_compute_out_valid_i,
    output load_counters_ctrl_o, load_sram_reg_en_ctrl_o, lb_pxl_cnt_en_ctrl_o,
           lb_pool_cnt_en_ctrl_o, win_valid_o, ch_idx_o, frame_done_o, sof_err_o
  );

endinterface

// File: rtl/fsm_pxl_counter.sv
// Column/row position of the next pixel in the frame. Column wraps at
// IMG_W-1 and bumps the row; after the last pixel both return to 0.
module fsm_pxl_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       adv_i,
  output logic [cnt_w(IMG_W)-1:0]    col_o,
  output logic [cnt_w(IMG_H)-1:0]    row_o,
  output logic                       last_o
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next position: clear wins over advance; hold when neither is asserted.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/fsm_conv_ctrl.sv
// Frame sequencer for a per-channel convolution pass: preload counters,
// load weights, fill the line buffer up to the first full window, stream
// the rest of the frame, then step to the next channel.
module fsm_conv_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int KERNEL  = DEF_KERNEL,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int POOL_EN = DEF_POOL_EN
) (
  input  logic                      fsm_clk,
  input  logic                      fsm_rst_b,
  input  logic                      sof_i,
  input  logic                      data_valid_i,
  input  logic                      sram_cnt_done_i,
  input  logic                      conv_compute_out_valid_i,
  output logic                      load_counters_ctrl_o,
  output logic                      load_sram_reg_en_ctrl_o,
  output logic                      lb_pxl_cnt_en_ctrl_o,
  output logic                      lb_pool_cnt_en_ctrl_o,
  output logic                      win_valid_o,
  output logic [cnt_w(NUM_CH)-1:0]  ch_idx_o,
  output logic                      frame_done_o,
  output logic                      sof_err_o
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int CH_W  = cnt_w(NUM_CH);
  localparam logic [COL_W-1:0] COL_KM1 = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_KM1 = ROW_W'(KERNEL - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);
  localparam bit               POOL_ON = (POOL_EN != 0);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic              pool_q, pool_d;
  logic              win_valid_q, win_valid_d;
  logic              sof_err_q, sof_err_d;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last_pxl;
  logic              accept;
  logic              fill_last;
  logic              win_hit;
  logic              cnt_clr;

  // Pixels only count while the line buffer is being filled or streamed.
  assign accept    = data_valid_i && ((state_q == S_FILL) || (state_q == S_CONV));
  assign fill_last = (row == ROW_KM1) && (col == COL_KM1);
  assign win_hit   = (row >= ROW_KM1) && (col >= COL_KM1);
  assign cnt_clr   = (state_d == S_LOAD) && (state_q != S_LOAD);

  fsm_pxl_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pxl_cnt (
    .clk    (fsm_clk),
    .rst_n  (fsm_rst_b),
    .clr_i  (cnt_clr),
    .adv_i  (accept),
    .col_o  (col),
    .row_o  (row),
    .last_o (last_pxl)
  );

  // State register.
  always_ff @(posedge fsm_clk or negedge fsm_rst_b) begin
    if (!fsm_rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d                 = state_q;
    load_counters_ctrl_o    = 1'b0;
    load_sram_reg_en_ctrl_o = 1'b0;
    lb_pxl_cnt_en_ctrl_o    = 1'b0;
    frame_done_o            = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_counters_ctrl_o = 1'b1;
        if (sof_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_sram_reg_en_ctrl_o = 1'b1;
        if (sram_cnt_done_i) state_d = S_FILL;
      end
      S_FILL: begin
        lb_pxl_cnt_en_ctrl_o = 1'b1;
        if (accept && fill_last) state_d = S_CONV;
      end
      S_CONV: begin
        lb_pxl_cnt_en_ctrl_o = 1'b1;
        if (accept && last_pxl) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done_o = 1'b1;
        state_d      = (ch_idx_q == CH_LAST) ? S_IDLE : S_LOAD;
      end
      default: begin
        load_counters_ctrl_o = 1'b1;
        state_d              = S_IDLE;
      end
    endcase
  end

  // Channel index, pool sticky flag and the two registered status pulses.
  always_comb begin
    ch_idx_d    = ch_idx_q;
    pool_d      = pool_q;
    win_valid_d = accept && win_hit;
    sof_err_d   = sof_i && (state_q != S_IDLE);
    if (state_q == S_DONE) begin
      pool_d   = 1'b0;
      ch_idx_d = (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + 1'b1;
    end else if (POOL_ON && (state_q == S_CONV) && conv_compute_out_valid_i) begin
      pool_d = 1'b1;
    end
  end

  // Status registers; reset aborts any channel pass without a done pulse.
  always_ff @(posedge fsm_clk or negedge fsm_rst_b) begin
    if (!fsm_rst_b) begin
      ch_idx_q    <= '0;
      pool_q      <= 1'b0;
      win_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      ch_idx_q    <= ch_idx_d;
      pool_q      <= pool_d;
      win_valid_q <= win_valid_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign ch_idx_o              = ch_idx_q;
  assign win_valid_o           = win_valid_q;
  assign sof_err_o             = sof_err_q;
  assign lb_pool_cnt_en_ctrl_o = POOL_ON && pool_q && (state_q == S_CONV);

endmodule
